// File: rtl/adc_stream_pkg.sv
// -----------------------------------------------------------------------------
// adc_stream_pkg
// Definitions shared by the ADC sample stream source:
//   - default widths for the raw sample, the stream word and the counters
//   - default elastic buffer depth
//   - the scan controller state type
// -----------------------------------------------------------------------------
package adc_stream_pkg;

    localparam int DEF_ADC_W      = 14;
    localparam int DEF_OUT_W      = 16;
    localparam int DEF_CNT_W      = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

endpackage

// File: rtl/adc_stream_tx_if.sv
// -----------------------------------------------------------------------------
// adc_stream_tx_if
// Avalon-ST data/valid/ready bundle (ready latency 0) between the ADC stream
// source and the adc_fifo_in sink.
//   data  : stream word, W bits
//   valid : source has a word on data
//   ready : sink accepts the word this cycle
// Modports: master (source side), slave (sink side).
// -----------------------------------------------------------------------------
interface adc_stream_tx_if
    import adc_stream_pkg::*;
#(
    parameter int W = DEF_OUT_W
);

    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/adc_stream_fifo.sv
// -----------------------------------------------------------------------------
// adc_stream_fifo
// Synchronous FIFO with zero-latency head read (dout shows the oldest entry).
// Ports:
//   clk, reset : clock, synchronous active-high reset (also used as flush)
//   push, din  : write request and data; ignored when full unless popping
//   pop        : read request; ignored when empty
//   dout       : head entry (undefined while empty)
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// when the index bits match.
// -----------------------------------------------------------------------------
module adc_stream_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO succeeds when the head leaves in the same cycle:
    // the freed slot is the one being written.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are meaningful, and an unreset array maps to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/adc_stream_tx.sv
// -----------------------------------------------------------------------------
// adc_stream_tx
// Producer end of the ADC sample stream. Gates raw ADC samples into echo
// windows, buffers them in a small elastic FIFO and presents them on an
// Avalon-ST source.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   adc_data, adc_dv  : raw offset-binary sample and its one-cycle strobe
//   acq_start         : arms a scan (only honoured in IDLE)
//   acq_abort         : terminates a scan, flushes the buffer, highest priority
//   echo_trig         : opens one echo window (only honoured in ARMED)
//   samples_per_echo  : samples per echo, latched at acq_start
//   echoes_per_scan   : echoes per scan, latched at acq_start
//   src               : stream source (data/valid/ready)
//   busy              : controller not idle
//   done              : one-cycle pulse when a scan finishes draining
//   overflow          : sticky, a sample was dropped on a full buffer
//   echo_cnt          : echoes completed in the current scan
// -----------------------------------------------------------------------------
module adc_stream_tx
    import adc_stream_pkg::*;
#(
    parameter int ADC_W      = DEF_ADC_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_dv,
    input  logic             acq_start,
    input  logic             acq_abort,
    input  logic             echo_trig,
    input  logic [CNT_W-1:0] samples_per_echo,
    input  logic [CNT_W-1:0] echoes_per_scan,
    adc_stream_tx_if.master  src,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] echo_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] spe_q, spe_d;
    logic [CNT_W-1:0] eps_q, eps_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] echo_cnt_q, echo_cnt_d;
    logic [CNT_W-1:0] echo_inc;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OUT_W-1:0] fifo_dout;

    // Abort flushes the buffer on the same edge that returns the FSM to IDLE.
    adc_stream_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset || acq_abort),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (OUT_W'(adc_data)),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Data is forced to zero while nothing is buffered so the bus never shows
    // stale or uninitialised storage.
    assign src.valid = !fifo_empty;
    assign src.data  = fifo_empty ? '0 : fifo_dout;
    assign fifo_pop  = src.valid && src.ready;

    assign echo_inc = echo_cnt_q + CNT_W'(1);

    // NOTE: every variable gets a default before the case statement so no
    // path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d      = state_q;
        spe_d        = spe_q;
        eps_d        = eps_q;
        sample_cnt_d = sample_cnt_q;
        echo_cnt_d   = echo_cnt_q;
        overflow_d   = overflow_q;
        done_d       = 1'b0;
        fifo_push    = 1'b0;

        if (acq_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acq_start) begin
                        spe_d        = samples_per_echo;
                        eps_d        = echoes_per_scan;
                        sample_cnt_d = '0;
                        echo_cnt_d   = '0;
                        overflow_d   = 1'b0;
                        // An empty configuration finishes immediately.
                        if (samples_per_echo == '0 || echoes_per_scan == '0)
                            state_d = ST_DRAIN;
                        else
                            state_d = ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (echo_trig) begin
                        sample_cnt_d = '0;
                        state_d      = ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    if (adc_dv) begin
                        fifo_push = 1'b1;
                        // Dropped samples still count so the echo boundary
                        // stays aligned with the acquisition timing.
                        if (fifo_full && !fifo_pop) overflow_d = 1'b1;
                        if (sample_cnt_q == spe_q - CNT_W'(1)) begin
                            sample_cnt_d = '0;
                            echo_cnt_d   = echo_inc;
                            state_d      = (echo_inc == eps_q) ? ST_DRAIN : ST_ARMED;
                        end else begin
                            sample_cnt_d = sample_cnt_q + CNT_W'(1);
                        end
                    end
                end

                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            spe_q        <= '0;
            eps_q        <= '0;
            sample_cnt_q <= '0;
            echo_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            spe_q        <= spe_d;
            eps_q        <= eps_d;
            sample_cnt_q <= sample_cnt_d;
            echo_cnt_q   <= echo_cnt_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign echo_cnt = echo_cnt_q;

endmodule

// File: doc/adc_stream_tx.md
Name: adc_stream_tx

Overview:
- Producer end of the ADC sample stream: an Avalon-ST source that drives the 16-bit adc_fifo_in sink (data/valid/ready) of the NMR SoC system.
- Gates raw ADC samples into echo windows using the HPS-programmed samples_per_echo and echoes_per_scan values.
- Holds samples in a small elastic buffer so sink backpressure never corrupts a sample, and reports overflow and completion status.

Parameters:
- ADC_W, 14, raw ADC sample width; must be ≤ OUT_W.
- OUT_W, 16, stream data width.
- FIFO_DEPTH, 4, elastic buffer depth; must be a power of 2 and ≥ 2.
- CNT_W, 32, width of the sample and echo counters.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- adc_data  in  ADC_W  raw ADC sample, offset binary.
- adc_dv  in  1  one-cycle strobe; adc_data is valid on this cycle.
- acq_start  in  1  pulse that arms a scan.
- acq_abort  in  1  pulse that terminates a scan.
- echo_trig  in  1  pulse that opens one echo window.
- samples_per_echo  in  CNT_W  samples captured per echo.
- echoes_per_scan  in  CNT_W  echoes per scan.
- src_data  out  OUT_W  stream data.
- src_valid  out  1  stream valid.
- src_ready  in  1  stream ready (ready latency 0).
- busy  out  1  high while state ≠ IDLE.
- done  out  1  one-cycle pulse at scan completion.
- overflow  out  1  sticky flag: a sample was dropped.
- echo_cnt  out  CNT_W  echoes completed in the current scan.

Behaviour:
- Reset: state=IDLE, FIFO empty, src_valid=0, src_data=0, busy=0, done=0, overflow=0, echo_cnt=0, internal sample_cnt=0.
- States: IDLE, ARMED, CAPTURE, DRAIN.
- Config latch: samples_per_echo and echoes_per_scan are latched on the accepted acq_start; later changes have no effect until the next scan.
- IDLE:
  - acq_start → ARMED; clears overflow and echo_cnt.
  - If either latched value is 0 → go to DRAIN instead; done fires once the FIFO is empty.
- ARMED: echo_trig → CAPTURE with sample_cnt=0.
- CAPTURE:
  - Each adc_dv pushes {zero-extend to OUT_W, adc_data} into the FIFO and increments sample_cnt.
  - On the strobe where sample_cnt reaches samples_per_echo−1: echo_cnt+1. If the new echo_cnt = echoes_per_scan → DRAIN, else → ARMED.
- DRAIN: FIFO empty → IDLE, with done=1 for exactly one cycle.
- Ignored events:
  - echo_trig outside ARMED.
  - adc_dv outside CAPTURE.
  - acq_start when state ≠ IDLE.
- Stream rules:
  - Transfer occurs when src_valid & src_ready.
  - src_data/src_valid are driven from the FIFO head and stay stable until accepted.
  - Once asserted, src_valid never drops without a transfer (except on abort or reset).
- Latency: adc_dv in cycle n with the FIFO empty → src_valid=1 in cycle n+1 carrying that sample.
- FIFO full: a push when full and no pop in that cycle drops the sample and sets overflow. The sample is still counted, preserving echo timing.
- Simultaneous push and pop when full: both succeed, no overflow.
- acq_abort (any state, has priority over all other events):
  - Next cycle: FIFO flushed, src_valid=0, state=IDLE.
  - No done pulse; overflow and echo_cnt retain their values.
- reset mid-scan: identical to reset values; no done pulse.
- Counters are unsigned CNT_W and never wrap within a scan, because terminal compares use the latched values.

Decomposition:
- Shared package adc_stream_pkg:
  - state enum (IDLE, ARMED, CAPTURE, DRAIN);
  - default widths ADC_W, OUT_W, CNT_W.
- One sub-module, adc_stream_fifo:
  - synchronous FIFO, parameterised width and depth;
  - ports: push, pop, din, dout, full, empty;
  - dout shows the head with zero read latency;
  - pointers carry an extra wrap bit for full/empty detection.

Test Plan:
- Basic scan: samples_per_echo=4, echoes_per_scan=2, src_ready=1; acq_start, echo_trig, 4 strobes of 0x0001..0x0004, echo_trig, 4 strobes of 0x0005..0x0008 → exactly 8 transfers 0x0001..0x0008 in order; echo_cnt=2; single done pulse after the last transfer; overflow=0.
- Backpressure: src_ready=0 with 3 strobes → src_valid=1 and src_data held at the first sample. Then src_ready=1 → 3 transfers in order, no loss.
- Overflow: FIFO_DEPTH=4, src_ready=0, 6 strobes → first 4 samples retained; overflow=1; scan still ends after 6 counted samples.
- Zero config: samples_per_echo=0, acq_start → done pulse within 3 cycles; no transfers.
- Abort: acq_abort mid-CAPTURE with 2 samples buffered → next cycle src_valid=0, busy=0, no done pulse; a subsequent acq_start runs a clean scan.
- Ignored events: echo_trig during CAPTURE and acq_start during ARMED → no change to state or counters; adc_dv in IDLE → no FIFO push.
